i2c_slave_mod: RTL

- I2C target (slave) endpoint: the far end of the I2C link driven by the team's I2C master.
- Used as an on-board peer and as a loopback target for the APB-controlled master.
- Holds four 8-bit registers behind a pointer byte; supports 7-bit addressing, multi-byte writes/reads with auto-increment, and repeated START.
- Runs entirely on PCLK, oversampling SCL/SDA; no clock stretching.

---
 rtl/i2c_slave_mod.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_mod.sv
// I2C target endpoint with four 8-bit registers behind a pointer byte.
// Oversamples SCL/SDA on PCLK; open-drain SDA via sda_oe, no clock stretching.
module i2c_slave_mod #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    output logic [31:0] regs_out,
    output logic        wr_strobe,
    output logic [1:0]  wr_index,
    output logic        busy
);

    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] ADDR      = 4'd1;
    localparam logic [3:0] ADDR_ACK  = 4'd2;
    localparam logic [3:0] PTR       = 4'd3;
    localparam logic [3:0] PTR_ACK   = 4'd4;
    localparam logic [3:0] WDATA     = 4'd5;
    localparam logic [3:0] WDATA_ACK = 4'd6;
    localparam logic [3:0] RDATA     = 4'd7;
    localparam logic [3:0] RDATA_ACK = 4'd8;
    localparam logic [3:0] WAIT_STOP = 4'd9;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_hist_q, sda_hist_q;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_c, stop_c;

    logic [3:0]      state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [6:0]      tx_q, tx_d;
    logic [1:0]      ptr_q, ptr_d;
    logic            rw_q, rw_d;
    logic            sda_oe_q, sda_oe_d;
    logic            busy_q, busy_d;
    logic            wr_strobe_q, wr_strobe_d;
    logic [1:0]      wr_index_q, wr_index_d;
    logic [3:0][7:0] regs_q, regs_d;
    logic            load_rd;
    logic [1:0]      rd_idx;
    logic [7:0]      rd_byte;

    // Synchronize the bus lines and keep one history sample for edges.
    // Reset to the idle-bus level so no false START follows reset.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
            scl_hist_q <= scl_sync_q[SYNC_STAGES-1];
            sda_hist_q <= sda_sync_q[SYNC_STAGES-1];
        end
    end

    assign scl_s    = scl_sync_q[SYNC_STAGES-1];
    assign sda_s    = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_hist_q;
    assign scl_fall = ~scl_s & scl_hist_q;
    assign start_c  = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
    assign stop_c   = scl_s & scl_hist_q & ~sda_hist_q & sda_s;

    // Protocol FSM: bus conditions first, then rising-edge sampling,
    // then falling-edge actions (the only place SDA drive changes).
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        ptr_d       = ptr_q;
        rw_d        = rw_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        wr_strobe_d = 1'b0;
        wr_index_d  = wr_index_q;
        regs_d      = regs_q;
        load_rd     = 1'b0;
        rd_idx      = ptr_q;
        rd_byte     = '0;
        if (stop_c) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_c) begin
            state_d  = ADDR;
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
        end else begin
            if (scl_rise) begin
                cnt_d   = cnt_q + 4'd1;
                shift_d = {shift_q[6:0], sda_s};
            end
            if (scl_fall) begin
                case (state_q)
                    ADDR: begin
                        if (cnt_q == 4'd8) begin
                            if (shift_q[7:1] == SLAVE_ADDR) begin
                                sda_oe_d = 1'b1;
                                busy_d   = 1'b1;
                                rw_d     = shift_q[0];
                                state_d  = ADDR_ACK;
                            end else begin
                                busy_d  = 1'b0;
                                state_d = IDLE;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (rw_q) begin
                            load_rd = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            cnt_d    = 4'd0;
                            state_d  = PTR;
                        end
                    end
                    PTR: begin
                        if (cnt_q == 4'd8) begin
                            ptr_d    = shift_q[1:0];
                            sda_oe_d = 1'b1;
                            state_d  = PTR_ACK;
                        end
                    end
                    PTR_ACK, WDATA_ACK: begin
                        sda_oe_d = 1'b0;
                        cnt_d    = 4'd0;
                        state_d  = WDATA;
                    end
                    WDATA: begin
                        if (cnt_q == 4'd8) begin
                            regs_d[ptr_q] = shift_q;
                            wr_strobe_d   = 1'b1;
                            wr_index_d    = ptr_q;
                            ptr_d         = ptr_q + 2'd1;
                            sda_oe_d      = 1'b1;
                            state_d       = WDATA_ACK;
                        end
                    end
                    RDATA: begin
                        if (cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            state_d  = RDATA_ACK;
                        end else begin
                            sda_oe_d = ~tx_q[6];
                            tx_d     = {tx_q[5:0], 1'b0};
                        end
                    end
                    RDATA_ACK: begin
                        if (!shift_q[0]) begin
                            ptr_d   = ptr_q + 2'd1;
                            rd_idx  = ptr_q + 2'd1;
                            load_rd = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = WAIT_STOP;
                        end
                    end
                    default: ;
                endcase
            end
            if (load_rd) begin
                rd_byte  = regs_q[rd_idx];
                tx_d     = rd_byte[6:0];
                sda_oe_d = ~rd_byte[7];
                cnt_d    = 4'd0;
                state_d  = RDATA;
            end
        end
    end

    // State and register-bank update.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            tx_q        <= '0;
            ptr_q       <= '0;
            rw_q        <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_index_q  <= '0;
            regs_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            ptr_q       <= ptr_d;
            rw_q        <= rw_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_strobe_d;
            wr_index_q  <= wr_index_d;
            regs_q      <= regs_d;
        end
    end

    assign sda_oe    = sda_oe_q;
    assign busy      = busy_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_index  = wr_index_q;
    assign regs_out  = regs_q;

endmodule
